// File: rtl/interrupt_ack_sequencer.sv
// Interrupt acknowledge sequencer: drives INT to the CPU and walks the
// two-pulse INTA handshake. It also maintains the in-service register and
// presents the vector byte during the second acknowledge.
module interrupt_ack_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       INTA_n,
    input  logic       intReq,
    input  logic [2:0] interruptLocation,
    input  logic [4:0] vectorBase,
    input  logic       autoEOI,
    input  logic       eoiCmd,
    input  logic       SPEN,
    input  logic       mPermissionToWrite,
    input  logic       sPermissionToWrite,
    output logic       INT,
    output logic [7:0] dataOut,
    output logic       dataOutEn,
    output logic [7:0] ISR,
    output logic       freezeIRR,
    output logic       ackDone
);

    typedef enum logic [2:0] {IDLE, REQ, ACK1, GAP, ACK2} state_t;

    state_t     state_q, state_d;
    logic       inta_prev_q;
    logic [2:0] level_q, level_d;
    logic       spurious_q, spurious_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] dout_q, dout_d;
    logic       isr_set, aeoi_clr;
    logic       inta_fall, inta_rise;

    // Edges are taken against the previous-cycle INTA_n sample
    assign inta_fall = inta_prev_q & ~INTA_n;
    assign inta_rise = ~inta_prev_q & INTA_n;

    // Sequencer next-state, level/spurious capture and vector latch
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        spurious_d = spurious_q;
        dout_d     = dout_q;
        isr_set    = 1'b0;
        aeoi_clr   = 1'b0;
        ackDone    = 1'b0;
        case (state_q)
            IDLE: if (intReq) state_d = REQ;
            REQ: begin
                if (inta_fall) begin
                    state_d = ACK1;
                    if (intReq) begin
                        level_d    = interruptLocation;
                        spurious_d = 1'b0;
                        isr_set    = 1'b1;
                    end else begin
                        // Request vanished before the acknowledge: answer
                        // with level 7 and leave ISR untouched
                        level_d    = 3'd7;
                        spurious_d = 1'b1;
                    end
                end
            end
            ACK1: if (inta_rise) state_d = GAP;
            GAP: begin
                if (inta_fall) begin
                    state_d = ACK2;
                    dout_d  = {vectorBase, level_q};
                end
            end
            ACK2: begin
                if (inta_rise) begin
                    state_d  = IDLE;
                    ackDone  = 1'b1;
                    aeoi_clr = autoEOI & ~spurious_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ISR update: EOI clears the lowest set bit of the old value, then the
    // AEOI clear and the new in-service set are layered on top
    always_comb begin
        isr_d = eoiCmd ? (isr_q & (isr_q - 8'd1)) : isr_q;
        if (aeoi_clr) isr_d[level_q] = 1'b0;
        if (isr_set)  isr_d[level_d] = 1'b1;
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            inta_prev_q <= 1'b1;
            level_q     <= 3'd0;
            spurious_q  <= 1'b0;
            isr_q       <= 8'h00;
            dout_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            inta_prev_q <= INTA_n;
            level_q     <= level_d;
            spurious_q  <= spurious_d;
            isr_q       <= isr_d;
            dout_q      <= dout_d;
        end
    end

    assign INT       = (state_q == REQ);
    assign freezeIRR = (state_q == ACK1) || (state_q == GAP) || (state_q == ACK2);
    assign dataOutEn = (state_q == ACK2) &&
                       ((SPEN & mPermissionToWrite) | (~SPEN & sPermissionToWrite));
    assign dataOut   = dout_q;
    assign ISR       = isr_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Bench for interrupt_ack_sequencer: directed acknowledge sequences with a
// scoreboard checking the vector presented at each ackDone pulse.
module tb_interrupt_ack_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       INTA_n, intReq, autoEOI, eoiCmd, SPEN, mPerm, sPerm;
    logic [2:0] loc;
    logic [4:0] vbase;
    logic       INT, dataOutEn, freezeIRR, ackDone;
    logic [7:0] dataOut, ISR;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] dout;
        logic       en;
        logic [7:0] isr;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    interrupt_ack_sequencer dut (
        .clk(clk), .rst(rst), .INTA_n(INTA_n), .intReq(intReq),
        .interruptLocation(loc), .vectorBase(vbase), .autoEOI(autoEOI),
        .eoiCmd(eoiCmd), .SPEN(SPEN), .mPermissionToWrite(mPerm),
        .sPermissionToWrite(sPerm), .INT(INT), .dataOut(dataOut),
        .dataOutEn(dataOutEn), .ISR(ISR), .freezeIRR(freezeIRR),
        .ackDone(ackDone)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Monitor: every ackDone pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && ackDone) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_ack: got ackDone=1 expected no pulse");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (dataOut !== e.dout || dataOutEn !== e.en || ISR !== e.isr) begin
                    errors++;
                    $display("FAIL sb_ack: got dout=%02h en=%0b isr=%02h expected dout=%02h en=%0b isr=%02h",
                             dataOut, dataOutEn, ISR, e.dout, e.en, e.isr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic eoi_pulse(input logic [7:0] exp_isr, input string name);
        eoiCmd = 1'b1;
        tick();
        eoiCmd = 1'b0;
        chk(name, ISR, exp_isr);
    endtask

    task automatic run_seq(input logic [2:0] l, input logic [4:0] b, input logic sp,
                           input logic mp, input logic spm, input logic aeoi,
                           input logic drop, input logic eoi_fall, input logic stoggle,
                           input logic [7:0] exp_isr_fall, input logic [7:0] exp_dout,
                           input logic exp_en, input logic [7:0] exp_isr_end);
        exp_t e;
        loc = l; vbase = b; SPEN = sp; mPerm = mp; sPerm = spm; autoEOI = aeoi;
        intReq = 1'b1;
        tick();
        chk("int_in_req", {7'd0, INT}, 8'd1);
        if (drop) begin
            intReq = 1'b0;
            tick();
            chk("int_held", {7'd0, INT}, 8'd1);
        end
        INTA_n = 1'b0;
        eoiCmd = eoi_fall;
        tick();
        eoiCmd = 1'b0;
        intReq = 1'b0;
        chk("isr_ack1", ISR, exp_isr_fall);
        chk("int_ack1", {7'd0, INT}, 8'd0);
        chk("frz_ack1", {7'd0, freezeIRR}, 8'd1);
        INTA_n = 1'b1;
        tick();
        INTA_n = 1'b0;
        tick();
        chk("dout_ack2", dataOut, exp_dout);
        if (stoggle) begin
            chk("en_slave_off", {7'd0, dataOutEn}, 8'd0);
            sPerm = 1'b1;
            #1;
            chk("en_slave_on", {7'd0, dataOutEn}, 8'd1);
            tick();
            chk("frz_hold", {7'd0, freezeIRR}, 8'd1);
            chk("dout_hold", dataOut, exp_dout);
            chk("en_hold", {7'd0, dataOutEn}, 8'd1);
        end else begin
            chk("en_ack2", {7'd0, dataOutEn}, {7'd0, exp_en});
        end
        e.dout = exp_dout; e.en = exp_en; e.isr = exp_isr_fall;
        sb.push_back(e);
        INTA_n = 1'b1;
        tick();
        chk("isr_end", ISR, exp_isr_end);
        chk("frz_end", {7'd0, freezeIRR}, 8'd0);
        chk("en_idle", {7'd0, dataOutEn}, 8'd0);
        chk("dout_idle", dataOut, exp_dout);
    endtask

    initial begin
        rst = 1'b1; INTA_n = 1'b1; intReq = 1'b0; autoEOI = 1'b0; eoiCmd = 1'b0;
        SPEN = 1'b1; mPerm = 1'b1; sPerm = 1'b0; loc = 3'd0; vbase = 5'd0;
        #1;
        chk("rst_int", {7'd0, INT}, 8'd0);
        chk("rst_dout", dataOut, 8'h00);
        chk("rst_isr", ISR, 8'h00);
        chk("rst_frz", {7'd0, freezeIRR}, 8'd0);
        chk("rst_ack", {7'd0, ackDone}, 8'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("idle_int", {7'd0, INT}, 8'd0);

        // Master, loc 3, base 0x11, no AEOI
        run_seq(3'd3, 5'h11, 1, 1, 0, 0, 0, 0, 0, 8'h08, 8'h8B, 1'b1, 8'h08);
        eoi_pulse(8'h00, "eoi_clr3");
        // Same with AEOI
        run_seq(3'd3, 5'h11, 1, 1, 0, 1, 0, 0, 0, 8'h08, 8'h8B, 1'b1, 8'h00);
        // Spurious: request dropped before first INTA, AEOI must not touch ISR
        run_seq(3'd3, 5'h08, 1, 1, 0, 1, 1, 0, 0, 8'h00, 8'h47, 1'b1, 8'h00);
        // Master without permission
        run_seq(3'd2, 5'h02, 1, 0, 1, 0, 0, 0, 0, 8'h04, 8'h12, 1'b0, 8'h04);
        eoi_pulse(8'h00, "eoi_clr2");
        // Slave: permission arrives mid-ACK2
        run_seq(3'd6, 5'h05, 0, 1, 0, 0, 0, 0, 1, 8'h40, 8'h2E, 1'b1, 8'h40);
        eoi_pulse(8'h00, "eoi_clr6");
        // Build ISR=0x28, EOI lowest, then EOI coincident with a set
        run_seq(3'd3, 5'h11, 1, 1, 0, 0, 0, 0, 0, 8'h08, 8'h8B, 1'b1, 8'h08);
        run_seq(3'd5, 5'h11, 1, 1, 0, 0, 0, 0, 0, 8'h28, 8'h8D, 1'b1, 8'h28);
        eoi_pulse(8'h20, "eoi_lowest");
        run_seq(3'd1, 5'h11, 1, 1, 0, 0, 0, 1, 0, 8'h02, 8'h89, 1'b1, 8'h02);
        eoi_pulse(8'h00, "eoi_last");
        eoi_pulse(8'h00, "eoi_empty");

        // Reset during GAP
        loc = 3'd4; vbase = 5'h11; intReq = 1'b1;
        tick();
        INTA_n = 1'b0;
        tick();
        intReq = 1'b0;
        INTA_n = 1'b1;
        tick();
        chk("gap_isr", ISR, 8'h10);
        chk("gap_frz", {7'd0, freezeIRR}, 8'd1);
        rst = 1'b1;
        #1;
        chk("arst_isr", ISR, 8'h00);
        chk("arst_frz", {7'd0, freezeIRR}, 8'd0);
        chk("arst_dout", dataOut, 8'h00);
        chk("arst_en", {7'd0, dataOutEn}, 8'd0);
        chk("arst_int", {7'd0, INT}, 8'd0);
        tick();
        rst = 1'b0;
        tick();
        INTA_n = 1'b0;
        tick();
        tick();
        chk("post_rst_int", {7'd0, INT}, 8'd0);
        chk("post_rst_frz", {7'd0, freezeIRR}, 8'd0);
        chk("post_rst_isr", ISR, 8'h00);
        INTA_n = 1'b1;
        tick(); tick();
        chk("post_rst_idle_frz", {7'd0, freezeIRR}, 8'd0);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_pending: got %0d unmatched entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
